seg_disp_sched: RTL
===================

Name: seg_disp_sched

Overview:
Time-shares the 8-digit hex 74HC595 display among N_SRC requesters, each presenting a 32-bit value. It arbitrates round-robin, holds each winner on the display for a fixed dwell period, and supports a lock mode that pins one source. Its disp_data0..3 outputs drive the data0..data3 inputs of the hex display driver directly.

Parameters:
N_SRC, 4, number of requesters (2..8)
DWELL_CYCLES, 50000000, sys_clk cycles a granted source stays on the display (1 s at 50 MHz); minimum 2
IDX_W, 2, width of the source index, equal to clog2(N_SRC)

Ports:
sys_clk  in  1  clock
sys_rst_n  in  1  reset; asynchronous, active-low
req  in  N_SRC  per-source display request, level
src_data  in  32*N_SRC  source i value at bits [32*i+31:32*i]
lock_en  in  1  pin the display to lock_sel
lock_sel  in  IDX_W  source to pin when lock_en=1
grant  out  N_SRC  one-hot current owner; all zero when idle
ack  out  1  one-cycle pulse when the owner's value is first latched
src_idx  out  IDX_W  index of the current or last owner
busy  out  1  1 in LOAD or SHOW
disp_data0  out  8  value[7:0] (digits 0,1)
disp_data1  out  8  value[15:8]
disp_data2  out  8  value[23:16]
disp_data3  out  8  value[31:24]

Behaviour:
- Reset (async, immediate): state=IDLE, grant=0, ack=0, busy=0, src_idx=0, disp_data0..3=0, dwell counter=0, rr pointer=N_SRC-1, so source 0 has first priority.
- States: IDLE, LOAD, SHOW.
- Arbitration function, applied in IDLE and at dwell expiry:
  - lock_en=1: the winner is lock_sel if req[lock_sel]=1; otherwise there is no winner.
  - lock_sel>=N_SRC means no winner.
  - lock_en=0: round-robin, first set req bit searching from pointer+1 upward with wrap.
- IDLE: on the edge where a winner exists:
  - grant<=onehot(winner), src_idx<=winner, pointer<=winner, busy<=1, state<=LOAD.
  - With no winner, the display keeps its last value.
- LOAD: exactly one cycle.
  - disp_data0..3 <= the owner's src_data slice, sampled this cycle even if req dropped.
  - ack<=1 for the following cycle only.
  - dwell<=DWELL_CYCLES-1, state<=SHOW.
- SHOW:
  - Live update: while req[owner]=1, disp_data tracks the owner slice each cycle (one-cycle register latency). When req[owner]=0 the display freezes.
  - The dwell counter decrements every cycle.
  - On the edge where dwell==0, re-arbitrate:
    - Winner exists (the same source included): grant/src_idx/pointer update, state<=LOAD. A re-grant to the same source re-pulses ack.
    - No winner: grant<=0, busy<=0, state<=IDLE, display held.
- Owner time on display = DWELL_CYCLES cycles in SHOW plus 1 LOAD cycle. Latency from req rising in IDLE to new disp_data = 2 edges.
- Simultaneous events:
  - lock_en rising mid-SHOW does not preempt; it takes effect at the next arbitration point.
  - Requests arriving mid-SHOW wait for expiry.
  - req and lock changes in the same cycle as expiry are sampled on that cycle.
- grant is always one-hot or zero. ack never pulses outside LOAD->SHOW.
- Reset asserted mid-LOAD or mid-SHOW: all outputs return to reset values immediately; no ack is emitted.

Decomposition:
- Package seg_disp_pkg: state encoding (IDLE=0, LOAD=1, SHOW=2), DEFAULT_DWELL=50000000, DIGITS=8, and a function for src_data slice extraction.
- One sub-module, seg_rr_arb: combinational round-robin picker.
  - Inputs: req, pointer, lock_en, lock_sel.
  - Outputs: win_valid, win_idx.
- Instantiated once; the FSM, counter and output registers stay in seg_disp_sched.

Test Plan:
- Run with N_SRC=4, DWELL_CYCLES=4.
- Reset then idle: req=0 for 20 cycles -> grant=0, busy=0, disp_data0..3=0, ack never high.
- Single source: req=0001, src_data[31:0]=0x12345678 -> ack pulses on the 2nd edge; disp_data3..0=12,34,56,78. ack re-pulses every 5 cycles while req is held.
- Round-robin: req=1111, values 0xA0..0xA3 in byte 0 -> grant sequence 0001,0010,0100,1000,0001, each held 5 cycles.
- Drop and live update:
  - Owner changes src_data to 0xDEADBEEF mid-SHOW -> display shows it the next cycle.
  - req then dropped -> display freezes at 0xDEADBEEF; FSM returns to IDLE at expiry with grant=0.
- Lock: req=1111, lock_en=1, lock_sel=2 raised mid-SHOW of source 0 -> source 0 completes its dwell, then grant=0100 repeatedly. lock_sel=2 with req[2]=0 -> IDLE, display held.
- Async reset mid-SHOW: sys_rst_n pulsed low for 1 ns -> grant=0, disp_data=0 immediately. Next grant is source 0.

Source files
------------

// File: rtl/seg_disp_pkg.sv
// Shared definitions for the multi-source hex display scheduler:
// FSM state encoding, default dwell period and the source word extractor.
`timescale 1ns/1ps
package seg_disp_pkg;

    // Scheduler FSM states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_SHOW = 2'd2
    } state_t;

    // One second at 50 MHz
    localparam int DEFAULT_DWELL = 50000000;
    // Hex digits on the physical display (one 32-bit word)
    localparam int DIGITS        = 8;
    // Largest supported requester count; source buses are padded to this
    localparam int MAX_SRC       = 8;
    localparam int SRC_PAD_W     = 32 * MAX_SRC;

    // Pick the 32-bit word of source idx out of a padded source bus
    function automatic logic [31:0] src_slice(input logic [SRC_PAD_W-1:0] bus,
                                              input logic [2:0]           idx);
        return bus[{idx, 5'b00000} +: 32];
    endfunction

endpackage

// File: rtl/seg_rr_arb.sv
// Combinational requester picker: round-robin after the pointer, or a
// single pinned source when lock mode is on.
`timescale 1ns/1ps
module seg_rr_arb #(
    parameter int N_SRC = 4,
    parameter int IDX_W = 2
) (
    input  logic [N_SRC-1:0] req,
    input  logic [IDX_W-1:0] pointer,
    input  logic             lock_en,
    input  logic [IDX_W-1:0] lock_sel,
    output logic             win_valid,
    output logic [IDX_W-1:0] win_idx
);

    localparam int PAD_W = 1 << IDX_W;

    // Pad bits above N_SRC are zero, so a lock_sel beyond the last
    // source naturally finds no request.
    logic [PAD_W-1:0] req_pad_s;
    int               cand_s;

    assign req_pad_s = PAD_W'(req);

    // Winner selection: pinned source or first request after the pointer
    always_comb begin
        win_valid = 1'b0;
        win_idx   = '0;
        cand_s    = 0;
        if (lock_en) begin
            if (req_pad_s[lock_sel]) begin
                win_valid = 1'b1;
                win_idx   = lock_sel;
            end else begin
                win_valid = 1'b0;
            end
        end else begin
            for (int k = 1; k <= N_SRC; k++) begin
                cand_s = (int'(pointer) + k) % N_SRC;
                if (!win_valid && req_pad_s[cand_s]) begin
                    win_valid = 1'b1;
                    win_idx   = IDX_W'(cand_s);
                end else begin
                    win_valid = win_valid;
                end
            end
        end
    end

endmodule

// File: rtl/seg_disp_sched.sv
// Time-shares the 8-digit hex display among N_SRC requesters. Each winner
// is loaded for one cycle, then shown for DWELL_CYCLES cycles with live
// update while it keeps requesting; arbitration happens in IDLE and at
// dwell expiry.
`timescale 1ns/1ps
module seg_disp_sched
    import seg_disp_pkg::*;
#(
    parameter int N_SRC        = 4,
    parameter int DWELL_CYCLES = DEFAULT_DWELL,
    parameter int IDX_W        = 2
) (
    input  logic                 sys_clk,
    input  logic                 sys_rst_n,
    input  logic [N_SRC-1:0]     req,
    input  logic [32*N_SRC-1:0]  src_data,
    input  logic                 lock_en,
    input  logic [IDX_W-1:0]     lock_sel,
    output logic [N_SRC-1:0]     grant,
    output logic                 ack,
    output logic [IDX_W-1:0]     src_idx,
    output logic                 busy,
    output logic [7:0]           disp_data0,
    output logic [7:0]           disp_data1,
    output logic [7:0]           disp_data2,
    output logic [7:0]           disp_data3
);

    localparam int DW_W  = $clog2(DWELL_CYCLES + 1);
    localparam int PAD_W = 1 << IDX_W;

    state_t             state_r,   state_nxt_s;
    logic [N_SRC-1:0]   grant_r,   grant_nxt_s;
    logic               ack_r,     ack_nxt_s;
    logic [IDX_W-1:0]   src_idx_r, src_idx_nxt_s;
    logic               busy_r,    busy_nxt_s;
    logic [31:0]        disp_r,    disp_nxt_s;
    logic [DW_W-1:0]    dwell_r,   dwell_nxt_s;
    logic [IDX_W-1:0]   ptr_r,     ptr_nxt_s;

    logic               win_valid_s;
    logic [IDX_W-1:0]   win_idx_s;
    logic [N_SRC-1:0]   win_onehot_s;
    logic [PAD_W-1:0]   req_pad_s;
    logic [SRC_PAD_W-1:0] src_pad_s;
    logic [31:0]        owner_word_s;
    logic               owner_req_s;
    logic               expire_s;

    seg_rr_arb #(
        .N_SRC (N_SRC),
        .IDX_W (IDX_W)
    ) u_arb (
        .req       (req),
        .pointer   (ptr_r),
        .lock_en   (lock_en),
        .lock_sel  (lock_sel),
        .win_valid (win_valid_s),
        .win_idx   (win_idx_s)
    );

    assign req_pad_s    = PAD_W'(req);
    assign src_pad_s    = SRC_PAD_W'(src_data);
    assign owner_word_s = src_slice(src_pad_s, 3'(src_idx_r));
    assign owner_req_s  = req_pad_s[src_idx_r];
    assign expire_s     = (dwell_r == DW_W'(0));
    assign win_onehot_s = {{(N_SRC-1){1'b0}}, 1'b1} << win_idx_s;

    // State register
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic: arbitrate in IDLE and at dwell expiry
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (win_valid_s) begin
                    state_nxt_s = ST_LOAD;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_LOAD: begin
                state_nxt_s = ST_SHOW;
            end
            ST_SHOW: begin
                if (expire_s && win_valid_s) begin
                    state_nxt_s = ST_LOAD;
                end else if (expire_s) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_SHOW;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Output/datapath next values: grant bookkeeping, display load, dwell
    always_comb begin
        grant_nxt_s   = grant_r;
        ack_nxt_s     = 1'b0;
        src_idx_nxt_s = src_idx_r;
        busy_nxt_s    = busy_r;
        disp_nxt_s    = disp_r;
        dwell_nxt_s   = dwell_r;
        ptr_nxt_s     = ptr_r;
        case (state_r)
            ST_IDLE: begin
                if (win_valid_s) begin
                    grant_nxt_s   = win_onehot_s;
                    src_idx_nxt_s = win_idx_s;
                    ptr_nxt_s     = win_idx_s;
                    busy_nxt_s    = 1'b1;
                end else begin
                    grant_nxt_s   = '0;
                    busy_nxt_s    = 1'b0;
                end
            end
            ST_LOAD: begin
                // Owner word is taken even if its request has just dropped
                disp_nxt_s  = owner_word_s;
                ack_nxt_s   = 1'b1;
                dwell_nxt_s = DW_W'(DWELL_CYCLES - 1);
            end
            ST_SHOW: begin
                if (owner_req_s) begin
                    disp_nxt_s = owner_word_s;
                end else begin
                    disp_nxt_s = disp_r;
                end
                if (expire_s && win_valid_s) begin
                    grant_nxt_s   = win_onehot_s;
                    src_idx_nxt_s = win_idx_s;
                    ptr_nxt_s     = win_idx_s;
                    busy_nxt_s    = 1'b1;
                end else if (expire_s) begin
                    grant_nxt_s   = '0;
                    busy_nxt_s    = 1'b0;
                end else begin
                    dwell_nxt_s   = dwell_r - DW_W'(1);
                end
            end
            default: begin
                grant_nxt_s   = '0;
                src_idx_nxt_s = '0;
                busy_nxt_s    = 1'b0;
                disp_nxt_s    = 32'h0000_0000;
                dwell_nxt_s   = '0;
                ptr_nxt_s     = IDX_W'(N_SRC - 1);
            end
        endcase
    end

    // Output and datapath registers; pointer resets so source 0 goes first
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            grant_r   <= '0;
            ack_r     <= 1'b0;
            src_idx_r <= '0;
            busy_r    <= 1'b0;
            disp_r    <= 32'h0000_0000;
            dwell_r   <= '0;
            ptr_r     <= IDX_W'(N_SRC - 1);
        end else begin
            grant_r   <= grant_nxt_s;
            ack_r     <= ack_nxt_s;
            src_idx_r <= src_idx_nxt_s;
            busy_r    <= busy_nxt_s;
            disp_r    <= disp_nxt_s;
            dwell_r   <= dwell_nxt_s;
            ptr_r     <= ptr_nxt_s;
        end
    end

    assign grant      = grant_r;
    assign ack        = ack_r;
    assign src_idx    = src_idx_r;
    assign busy       = busy_r;
    assign disp_data0 = disp_r[7:0];
    assign disp_data1 = disp_r[15:8];
    assign disp_data2 = disp_r[23:16];
    assign disp_data3 = disp_r[31:24];

endmodule
